// File: rtl/pipeline_hazard_ctrl_8085_pkg.sv
// hazard_pkg_8085: shared types and constants for the 8085-style pipeline
// hazard controller.
//   - FSM state encodings (RUN / JHOLD / FLUSH)
//   - operand-forwarding select encodings (FWD_RF / FWD_EX / FWD_WB)
//   - register-index width and the default accumulator index
//   - the EX/WB shadow record and the forwarding-select helper
package hazard_pkg_8085;

    localparam int REG_IDX_W = 3;
    localparam logic [REG_IDX_W-1:0] ACC_IDX_DEFAULT = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_JHOLD = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_WB = 2'b10
    } fwd_t;

    // What the controller remembers about an instruction in EX or WB.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dst;
        logic                 wr;
        logic                 mem_rd;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

    // EX wins over WB so the youngest producer is always selected. A load in
    // EX cannot forward (its data only exists at WB), so it falls through.
    function automatic fwd_t fwd_select(
        input logic                 use_src,
        input logic [REG_IDX_W-1:0] src,
        input shadow_t              ex,
        input shadow_t              wb
    );
        fwd_t sel;
        sel = FWD_RF;
        if (use_src) begin
            if (ex.valid && ex.wr && !ex.mem_rd && (ex.dst == src)) begin
                sel = FWD_EX;
            end else if (wb.valid && wb.wr && (wb.dst == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_8085_scoreboard.sv
// hazard_scoreboard_8085: EX/WB shadow registers plus the load-use and
// forwarding comparators.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   id_*                  fields of the instruction currently in ID
//   advance               ID instruction moves into EX this cycle
//   load_use              combinational load-use hazard against EX
//   fwd_a, fwd_b          operand source selects (00 RF, 01 EX, 10 WB)
module hazard_scoreboard_8085
    import hazard_pkg_8085::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src_a,
    input  logic [REG_IDX_W-1:0] id_src_b,
    input  logic                 id_use_a,
    input  logic                 id_use_b,
    input  logic [REG_IDX_W-1:0] id_dst,
    input  logic                 id_wr,
    input  logic                 id_mem_rd,
    input  logic                 advance,
    output logic                 load_use,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b
);

    shadow_t ex_q, ex_d;
    shadow_t wb_q, wb_d;

    // WB never feeds a hazard decision through its mem_rd bit; it is kept
    // only so both shadows carry the same record.
    logic wb_mem_rd_unused;
    assign wb_mem_rd_unused = wb_q.mem_rd;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        ex_d = SHADOW_EMPTY;
        if (advance) begin
            ex_d.valid  = 1'b1;
            ex_d.dst    = id_dst;
            ex_d.wr     = id_wr;
            ex_d.mem_rd = id_mem_rd;
        end
        wb_d = ex_q;
    end

    // NOTE: the shadows are tiny control flops, so they are reset to a bubble; stale wr bits would fake hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= SHADOW_EMPTY;
            wb_q <= SHADOW_EMPTY;
        end else begin
            // NOTE: non-blocking so WB samples the old EX value on the same edge.
            ex_q <= ex_d;
            wb_q <= wb_d;
        end
    end

    logic hit_a, hit_b;

    always_comb begin
        hit_a    = id_use_a && (ex_q.dst == id_src_a);
        hit_b    = id_use_b && (ex_q.dst == id_src_b);
        load_use = id_valid && ex_q.valid && ex_q.wr && ex_q.mem_rd && (hit_a || hit_b);
        fwd_a    = fwd_select(id_use_a, id_src_a, ex_q, wb_q);
        fwd_b    = fwd_select(id_use_b, id_src_b, ex_q, wb_q);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl_8085.sv
// pipeline_hazard_ctrl_8085: hazard controller for a short in-order pipeline.
// Detects load-use stalls, selects operand forwarding and sequences the
// jump penalty (hold IF/ID, then either resume or flush on a taken jump).
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   id_valid, id_src_a/b,
//   id_use_a/b, id_dst, id_wr,
//   id_mem_rd, id_jump           decoded fields of the ID instruction
//   ex_taken                     jump in EX resolves taken
//   stall, flush                 pipeline hold / IF-ID kill
//   fwd_a, fwd_b                 operand source selects
//   stall_jump                   jump-penalty hold active
//   state                        FSM state, debug only
module pipeline_hazard_ctrl_8085
    import hazard_pkg_8085::*;
#(
    parameter int                   JUMP_PENALTY = 2,
    parameter logic [REG_IDX_W-1:0] ACC_IDX      = ACC_IDX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src_a,
    input  logic [REG_IDX_W-1:0] id_src_b,
    input  logic                 id_use_a,
    input  logic                 id_use_b,
    input  logic [REG_IDX_W-1:0] id_dst,
    input  logic                 id_wr,
    input  logic                 id_mem_rd,
    input  logic                 id_jump,
    input  logic                 ex_taken,
    output logic                 stall,
    output logic                 flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 stall_jump,
    output logic [1:0]           state
);

    localparam logic [2:0] PENALTY = 3'(JUMP_PENALTY);

    // The accumulator is an ordinary register index to the hazard logic;
    // the parameter only documents its encoding.
    logic acc_idx_unused;
    assign acc_idx_unused = ^ACC_IDX;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       advance;

    hazard_scoreboard_8085 u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_src_a  (id_src_a),
        .id_src_b  (id_src_b),
        .id_use_a  (id_use_a),
        .id_use_b  (id_use_b),
        .id_dst    (id_dst),
        .id_wr     (id_wr),
        .id_mem_rd (id_mem_rd),
        .advance   (advance),
        .load_use  (load_use),
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A jump only enters JHOLD once it really leaves ID,
    // so a coincident load-use stall delays the hold by a cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (id_valid && id_jump && !stall) begin
                    state_d = ST_JHOLD;
                    cnt_d   = PENALTY;
                end
            end
            ST_JHOLD: begin
                cnt_d = cnt_q - 3'd1;
                if (ex_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Output logic. FLUSH overrides a load-use stall: the ID instruction is
    // being killed, so there is nothing to hold.
    always_comb begin
        stall_jump = (state_q == ST_JHOLD);
        flush      = (state_q == ST_FLUSH);
        stall      = !flush && (load_use || stall_jump);
        advance    = id_valid && !stall && !flush && !stall_jump;
        state      = state_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl_8085.sv
// Self-checking bench for pipeline_hazard_ctrl_8085 (JUMP_PENALTY = 2).
// Each step drives the ID fields, pushes the expected output vector
// {stall, flush, stall_jump, state[1:0], fwd_a[1:0], fwd_b[1:0]} and pops it
// at the following falling edge for comparison.
module tb_pipeline_hazard_ctrl_8085;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_a, id_use_b, id_wr, id_mem_rd, id_jump, ex_taken;
    logic [2:0] id_src_a, id_src_b, id_dst;
    logic       stall, flush, stall_jump;
    logic [1:0] fwd_a, fwd_b, state;

    int tests  = 0;
    int failed = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got, want;

    typedef struct packed {
        logic       valid;
        logic [2:0] sa;
        logic       ua;
        logic [2:0] sb;
        logic       ub;
        logic [2:0] dst;
        logic       wr;
        logic       mr;
        logic       jump;
        logic       taken;
        logic [8:0] exp;
    } step_t;

    pipeline_hazard_ctrl_8085 #(.JUMP_PENALTY(2), .ACC_IDX(3'd7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_dst     (id_dst),
        .id_wr      (id_wr),
        .id_mem_rd  (id_mem_rd),
        .id_jump    (id_jump),
        .ex_taken   (ex_taken),
        .stall      (stall),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_jump (stall_jump),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] e(input logic s, input logic f, input logic sj,
                                     input logic [1:0] st, input logic [1:0] fa,
                                     input logic [1:0] fb);
        return {s, f, sj, st, fa, fb};
    endfunction

    function automatic step_t mk(input logic v, input logic [2:0] sa, input logic ua,
                                 input logic [2:0] sb, input logic ub, input logic [2:0] dst,
                                 input logic wr, input logic mr, input logic jump,
                                 input logic taken, input logic [8:0] exp);
        step_t s;
        s = '{valid: v, sa: sa, ua: ua, sb: sb, ub: ub, dst: dst, wr: wr, mr: mr,
              jump: jump, taken: taken, exp: exp};
        return s;
    endfunction

    function automatic step_t idle(input logic taken, input logic [8:0] exp);
        return mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, taken, exp);
    endfunction

    function automatic logic [8:0] observe();
        return {stall, flush, stall_jump, state, fwd_a, fwd_b};
    endfunction

    task automatic set_in(input step_t s);
        id_valid  = s.valid;
        id_src_a  = s.sa;
        id_use_a  = s.ua;
        id_src_b  = s.sb;
        id_use_b  = s.ub;
        id_dst    = s.dst;
        id_wr     = s.wr;
        id_mem_rd = s.mr;
        id_jump   = s.jump;
        ex_taken  = s.taken;
    endtask

    task automatic test_reset();
        set_in(mk(1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 9'd0));
        rst_n = 1'b0;
        #2;
        exp_q.push_back(9'd0);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL reset_initial: got %b expected %b", got, want);
        end
        @(negedge clk); @(negedge clk);
        exp_q.push_back(9'd0);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL reset_held: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_in(idle(1'b0, 9'd0));
        exp_q.push_back(9'd0);
        @(negedge clk);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL reset_release: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        step_t seq[$];
        seq.push_back(idle(1'b0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        // ADD r7
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b00, 2'b00)));
        // MOV r2 <- r7: ADD in EX
        seq.push_back(mk(1, 3'd7, 1, 3'd0, 0, 3'd2, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b01, 2'b00)));
        // r7 from WB on a, r2 from EX on b
        seq.push_back(mk(1, 3'd7, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b10, 2'b01)));
        // a unused; src 7 vs EX dst 3 differ only in bit 2
        seq.push_back(mk(1, 3'd3, 0, 3'd7, 1, 3'd7, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd7, 1, 3'd0, 0, 3'd7, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b01, 2'b00)));
        // r7 in both EX and WB: EX wins
        seq.push_back(mk(1, 3'd7, 1, 3'd7, 1, 3'd0, 0, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b01, 2'b01)));
        // EX does not write, WB has r7
        seq.push_back(mk(1, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b10, 2'b00)));
        seq.push_back(idle(1'b0, 9'd0));
        for (int i = 0; i < seq.size(); i++) begin
            set_in(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL forward step %0d: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t seq[$];
        seq.push_back(idle(1'b0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        // LD r1
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0, 9'd0));
        // user of r1 on b: one stall cycle, then WB forward
        seq.push_back(mk(1, 3'd0, 0, 3'd1, 1, 3'd4, 1, 0, 0, 0, e(1, 0, 0, 2'd0, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd1, 1, 3'd4, 1, 0, 0, 0, e(0, 0, 0, 2'd0, 2'b00, 2'b10)));
        seq.push_back(idle(1'b0, 9'd0));
        // LD r5, then an invalid slot naming r5: no stall
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 9'd0));
        seq.push_back(mk(0, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        for (int i = 0; i < seq.size(); i++) begin
            set_in(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL load_use step %0d: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_not_taken();
        step_t seq[$];
        seq.push_back(idle(1'b0, 9'd0));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 9'd0));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(1, 0, 1, 2'd1, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(1, 0, 1, 2'd1, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 9'd0));
        // ex_taken in RUN has no effect
        seq.push_back(idle(1'b1, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        for (int i = 0; i < seq.size(); i++) begin
            set_in(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL jump_not_taken step %0d: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump_taken();
        step_t seq[$];
        seq.push_back(idle(1'b0, 9'd0));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 9'd0));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1, e(1, 0, 1, 2'd1, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(0, 1, 0, 2'd2, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        for (int i = 0; i < seq.size(); i++) begin
            set_in(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL jump_taken step %0d: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_and_jump();
        step_t seq[$];
        seq.push_back(idle(1'b0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        // LD r2, then a jump that reads r2
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0, 9'd0));
        seq.push_back(mk(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 1, 0, e(1, 0, 0, 2'd0, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd2, 1, 3'd0, 0, 3'd0, 0, 0, 1, 0, e(0, 0, 0, 2'd0, 2'b10, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(1, 0, 1, 2'd1, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, e(1, 0, 1, 2'd1, 2'b00, 2'b00)));
        seq.push_back(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 9'd0));
        seq.push_back(idle(1'b0, 9'd0));
        for (int i = 0; i < seq.size(); i++) begin
            set_in(seq[i]);
            exp_q.push_back(seq[i].exp);
            @(negedge clk);
            got = observe(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL stall_and_jump step %0d: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_jhold();
        // jump that also writes r6
        set_in(mk(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 0, 1, 0, 9'd0));
        exp_q.push_back(9'd0);
        @(negedge clk);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_jump: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        set_in(mk(1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, 9'd0));
        exp_q.push_back(e(1, 0, 1, 2'd1, 2'b01, 2'b00));
        @(negedge clk);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_jhold: got %b expected %b", got, want);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_q.push_back(9'd0);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_async: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        exp_q.push_back(9'd0);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_held: got %b expected %b", got, want);
        end
        rst_n = 1'b1;
        exp_q.push_back(9'd0);
        @(negedge clk);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_release: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        set_in(idle(1'b0, 9'd0));
        exp_q.push_back(9'd0);
        @(negedge clk);
        got = observe(); want = exp_q.pop_front(); tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL rst_mid_no_flush: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_jump_not_taken();
        test_jump_taken();
        test_stall_and_jump();
        test_reset_mid_jhold();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl_8085.md
PIPELINE_HAZARD_CTRL_8085 -- requirements
Module: pipeline_hazard_ctrl_8085

Interface
REQ-001 SHALL have parameter JUMP_PENALTY, default 2: number of cycles IF/ID are held after a jump leaves ID, range 1..7.
REQ-002 SHALL have parameter ACC_IDX, default 3'd7: register index that denotes the accumulator.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-006 SHALL have ports id_src_a and id_src_b, input, 3 bits each: source register indices.
REQ-007 SHALL have ports id_use_a and id_use_b, input, 1 bit each: the matching source is actually read.
REQ-008 SHALL have port id_dst, input, 3 bits: destination register index.
REQ-009 SHALL have port id_wr, input, 1 bit: the instruction writes id_dst.
REQ-010 SHALL have port id_mem_rd, input, 1 bit: the result is available only at WB (memory load).
REQ-011 SHALL have port id_jump, input, 1 bit: the instruction in ID is a jump.
REQ-012 SHALL have port ex_taken, input, 1 bit: the jump now in EX resolves as taken.
REQ-013 SHALL have port stall, output, 1 bit: hold PC and IF/ID, inject a bubble into EX.
REQ-014 SHALL have port flush, output, 1 bit: kill the instruction in IF/ID.
REQ-015 SHALL have ports fwd_a and fwd_b, output, 2 bits each: operand source select, 00 regfile, 01 EX result, 10 WB result.
REQ-016 SHALL have port stall_jump, output, 1 bit: a jump-penalty hold is in progress.
REQ-017 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-018 SHALL keep internal EX and WB shadows of each instruction: valid, dst, wr, mem_rd.
- Each cycle WB takes the EX shadow.
- EX takes the ID fields when id_valid & !stall & !flush & !stall_jump; otherwise EX takes a bubble (wr=0).
REQ-019 SHALL raise stall combinationally on a load-use hazard:
- EX shadow has wr & mem_rd, and
- its dst matches a used source in ID (id_src_a with id_use_a, or id_src_b with id_use_b), and
- id_valid is high.
REQ-020 SHALL set fwd_x to 01 when EX has wr & !mem_rd and its dst equals src_x; otherwise 10 when WB has wr and its dst equals src_x; otherwise 00.
- EX takes priority over WB.
- fwd_x is 00 when use_x is 0.
REQ-021 SHALL implement FSM states RUN=0, JHOLD=1, FLUSH=2.
REQ-022 RUN->JHOLD SHALL occur when id_valid & id_jump & !stall; the penalty counter then loads JUMP_PENALTY.
REQ-023 In JHOLD:
- stall_jump=1 and stall=1.
- The counter decrements each cycle.
- ex_taken=1 moves the FSM to FLUSH, with priority over the counter.
- When the counter reaches 1 with no taken jump, the FSM returns to RUN.
REQ-024 In FLUSH, flush=1 for exactly one cycle, stall=0, then the FSM returns to RUN.
REQ-025 A load-use stall and a jump in ID at the same time SHALL give stall priority; JHOLD is entered only on the cycle the jump actually leaves ID.
REQ-026 ex_taken while in RUN SHALL be ignored.
REQ-027 Comparisons SHALL use all 3 index bits; ACC_IDX SHALL get no special treatment apart from its encoding.

Reset
REQ-028 While rst_n=0, and immediately on assertion:
- state=RUN, counter=0, EX and WB shadows invalid with wr=0.
- stall=0, flush=0, stall_jump=0, fwd_a=fwd_b=00.
REQ-029 Reset asserted in the middle of JHOLD or FLUSH SHALL abort that state with no residual flush; the first cycle after release is RUN.

Structure
REQ-030 Package hazard_pkg_8085 SHALL hold:
- the FSM state encodings;
- the fwd encodings FWD_RF, FWD_EX and FWD_WB;
- the ACC_IDX default;
- the register-index width constant.
REQ-031 The EX/WB shadow and comparator logic SHALL be one sub-module, hazard_scoreboard_8085; the FSM and counter SHALL stay in the top module.

Verification
REQ-032 Stimulus: ADD with dst=7, then MOV with src_a=7 on the next cycle.
- Required: fwd_a=01, stall=0.
- One cycle later, with an unrelated instruction in between: fwd_a=10.
REQ-033 Stimulus: load with dst=1 (mem_rd=1), then an instruction with src_b=1 and use_b=1.
- Required: stall=1 for exactly 1 cycle, then fwd_b=10 and stall=0.
REQ-034 Stimulus: jump in ID with JUMP_PENALTY=2 and ex_taken=0.
- Required: stall_jump=1 for 2 cycles, state 0->1->1->0, flush never asserted.
REQ-035 Stimulus: jump followed by ex_taken=1 in the first JHOLD cycle.
- Required: state 1->2->0, flush=1 for one cycle, stall_jump=0 during FLUSH.
REQ-036 Stimulus: load-use hazard coincident with a jump in ID.
- Required: stall first, JHOLD entered one cycle later.
REQ-037 Stimulus: rst_n pulsed low mid-JHOLD.
- Required: all outputs 0 asynchronously, state=0 after release.
